prog_clock_divider: RTL and testbench
=====================================

// Module: prog_clock_divider
// PURPOSE
//  Multi-channel, runtime-programmable integer clock divider; successor to the fixed-ratio divider.
//  Each channel divides clk by its own ratio N, loaded at run time.
//  Ratio changes apply only at period boundaries, so no glitches or runt pulses occur.
//  Outputs feed peripheral clock-enable domains and slow test clocks.
// PARAMETERS
//  WIDTH        8   bits per ratio field; max N = 2**WIDTH-1
//  NUM_CH       2   number of independent divider channels
//  DEFAULT_DIV  4   active and shadow ratio of every channel after reset (>=2)
// PORTS
//  clk        in   1             single system clock, all logic on posedge
//  reset      in   1             asynchronous, active-high reset
//  enable     in   NUM_CH        per-channel run enable
//  load       in   NUM_CH        per-channel one-cycle strobe: capture div_ratio slice into shadow
//  div_ratio  in   NUM_CH*WIDTH  ratio for channel i in bits [i*WIDTH +: WIDTH]
//  clk_out    out  NUM_CH        divided clock per channel
//  tick       out  NUM_CH        one-clk pulse in the cycle clk_out rises
//  pending    out  NUM_CH        high while shadow ratio is not yet active
// BEHAVIOUR
//  - Reset (async, any time, including mid-period): cnt=0, active=shadow=DEFAULT_DIV, clk_out=0, tick=0, pending=0.
//  - Ratio clamp: a loaded value of 0 or 1 is stored as 2.
//  - H = active>>1 (floor).
//  - Per channel, at posedge clk while enable=1:
//      cnt <= (cnt==N-1) ? 0 : cnt+1
//      tick <= (cnt==N-1)
//      clk_out <= 1 when cnt==N-1; clk_out <= 0 when cnt==H-1; otherwise clk_out holds.
//  - Timing: first clk_out rise occurs at the N-th enabled posedge after reset release.
//    clk_out then stays high H clk periods and low N-H periods. Odd N gives a short high phase.
//  - Load, channel enabled: shadow <= clamp(div_ratio slice) and pending <= 1.
//    At the next wrap (cnt==N-1): active <= shadow, pending <= 0.
//    The new ratio governs the whole following period.
//  - Load in the same cycle as a wrap: the new value bypasses the shadow, becomes active at that wrap, and pending stays 0.
//  - Load while busy: a second load before the wrap overwrites the shadow. Last value wins.
//  - enable=0: cnt and clk_out freeze at their current values; tick=0.
//  - Load while enable=0: applies immediately: active <= value, cnt <= 0, clk_out <= 0, pending=0.
//  - Channels are fully independent. A load or enable on one channel never disturbs the others.
// CONFIGURATION
//  Macro ODD_DUTY50_EN.
//  - Defined: each channel adds a negedge flop q_n <= clk_out_q.
//    For odd active N, clk_out = clk_out_q | q_n, giving high N/2 and low N/2 clk periods (50% duty).
//    For even N, clk_out = clk_out_q unchanged. tick is unaffected.
//    The negedge flop resets asynchronously to 0.
//  - Undefined: no negedge logic; odd N yields high floor(N/2), low ceil(N/2).
// STRUCTURE
//  - clk_div_pkg: MIN_DIV=2, clamp_ratio() function, half_ratio() function.
//  - Sub-module clk_div_channel (one divider channel, WIDTH parameter), instantiated NUM_CH times by generate.
//    Top level only slices buses.
// TESTING
//  1. Reset 1 then 0, enable=11, defaults, clk period 2 -> clk_out[0] first rise at 4th posedge; period 8, 4 high/4 low; tick every 4 clks.
//  2. load ch0 with 6 mid-period -> pending[0]=1; current period of 4 completes, pending clears at wrap; next periods 12 (6 clk).
//  3. load ch1 with 5, ODD_DUTY50_EN undefined -> 2 clk high/3 clk low.
//     Rebuilt with macro -> 2.5/2.5 clk high/low.
//  4. load with 0 and with 1 -> both behave as N=2: clk_out toggles every clk, tick every 2 clks.
//  5. enable[0]=0 mid-high phase -> clk_out[0] frozen high, ch1 unaffected.
//     load 3 while disabled -> clk_out[0]=0, cnt=0; re-enable -> rise after 3 posedges.
//  6. Assert reset during pending load -> all outputs 0, active=DEFAULT_DIV, shadow discarded.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the programmable clock divider.
//   MIN_DIV       smallest ratio a channel will ever run at
//   clamp_ratio() maps a requested ratio onto the legal range (0/1 -> MIN_DIV)
//   half_ratio()  length of the high phase, floor(N/2)
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned clamp_ratio(input int unsigned ratio);
        return (ratio < MIN_DIV) ? MIN_DIV : ratio;
    endfunction

    function automatic int unsigned half_ratio(input int unsigned ratio);
        return ratio >> 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
// One runtime-programmable integer divider channel. A new ratio is held in a
// shadow register and only becomes active at a period boundary, so the output
// never produces a runt pulse.
// Optional feature: define ODD_DUTY50_EN to add a negedge stage that stretches
// the high phase of odd ratios to N/2 clk periods (50% duty).
// Ports:
//   i_clk      system clock (posedge)
//   i_reset    asynchronous active-high reset
//   i_enable   run enable; when low the counter and output freeze
//   i_load     one-cycle strobe capturing i_ratio
//   i_ratio    requested ratio (0 and 1 are clamped to 2)
//   o_clk_out  divided clock
//   o_tick     one-cycle pulse in the cycle o_clk_out rises
//   o_pending  a loaded ratio is waiting for the next period boundary
// -----------------------------------------------------------------------------
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_ratio,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pending
);

    localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(clamp_ratio(DEFAULT_DIV));
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_shadow;
    logic             r_clk_q;
    logic             r_tick;
    logic             r_pending;

    logic [WIDTH-1:0] w_ratio;
    logic [WIDTH-1:0] w_half;
    logic             w_wrap;
    logic             w_half_hit;

    assign w_ratio    = WIDTH'(clamp_ratio(32'(i_ratio)));
    assign w_half     = WIDTH'(half_ratio(32'(r_active)));
    // active >= 2 always, so both compares stay inside the count range
    assign w_wrap     = (r_cnt == r_active - ONE);
    assign w_half_hit = (r_cnt == w_half - ONE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_active  <= DEF_RATIO;
            r_shadow  <= DEF_RATIO;
            r_clk_q   <= 1'b0;
            r_tick    <= 1'b0;
            r_pending <= 1'b0;
        end else if (!i_enable) begin
            r_tick <= 1'b0;
            // No period is running, so a load takes effect at once
            if (i_load) begin
                r_active  <= w_ratio;
                r_shadow  <= w_ratio;
                r_cnt     <= '0;
                r_clk_q   <= 1'b0;
                r_pending <= 1'b0;
            end
        end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
                r_cnt     <= '0;
                r_clk_q   <= 1'b1;
                r_pending <= 1'b0;
                // A load coinciding with the wrap bypasses the shadow
                if (i_load) begin
                    r_active <= w_ratio;
                    r_shadow <= w_ratio;
                end else begin
                    r_active <= r_shadow;
                end
            end else begin
                r_cnt <= r_cnt + ONE;
                if (w_half_hit) begin
                    r_clk_q <= 1'b0;
                end
                if (i_load) begin
                    r_shadow  <= w_ratio;
                    r_pending <= 1'b1;
                end
            end
        end
    end

`ifdef ODD_DUTY50_EN
    logic r_q_n;

    // Half-cycle delayed copy extends the high phase by half a clk for odd N
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_q_n <= 1'b0;
        end else begin
            r_q_n <= r_clk_q;
        end
    end

    assign o_clk_out = r_active[0] ? (r_clk_q | r_q_n) : r_clk_q;
`else
    assign o_clk_out = r_clk_q;
`endif

    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/prog_clock_divider.sv
// -----------------------------------------------------------------------------
// prog_clock_divider
// Multi-channel runtime-programmable integer clock divider. Each channel is an
// independent clk_div_channel; this level only slices the buses.
// Optional feature: ODD_DUTY50_EN (50% duty for odd ratios, see channel).
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   enable     per-channel run enable            [NUM_CH]
//   load       per-channel ratio load strobe      [NUM_CH]
//   div_ratio  channel i ratio in [i*WIDTH +: WIDTH]
//   clk_out    per-channel divided clock          [NUM_CH]
//   tick       per-channel rising-edge pulse      [NUM_CH]
//   pending    per-channel shadow-not-yet-active  [NUM_CH]
// -----------------------------------------------------------------------------
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] div_ratio,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk     (clk),
            .i_reset   (reset),
            .i_enable  (enable[g]),
            .i_load    (load[g]),
            .i_ratio   (div_ratio[g*WIDTH +: WIDTH]),
            .o_clk_out (clk_out[g]),
            .o_tick    (tick[g]),
            .o_pending (pending[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clock_divider
// Directed bench for prog_clock_divider. Expected period/high-phase lengths are
// queued per channel; a monitor measures each period between ticks and checks
// it against the queue. Reset, pending, freeze and first-rise latency are
// checked directly. Honours ODD_DUTY50_EN for the odd-ratio high phases.
// -----------------------------------------------------------------------------
module tb_prog_clock_divider;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned BOUND  = 100;

`ifdef ODD_DUTY50_EN
    localparam int unsigned HI3 = 2;
    localparam int unsigned HI5 = 3;
`else
    localparam int unsigned HI3 = 1;
    localparam int unsigned HI5 = 2;
`endif

    typedef struct {
        int unsigned per;
        int unsigned hi;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] div_ratio;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pending;

    logic [NUM_CH-1:0]       mon_en;
    exp_t                    q0[$];
    exp_t                    q1[$];
    int unsigned             n_checks = 0;
    int unsigned             n_err    = 0;

    prog_clock_divider #(
        .WIDTH       (WIDTH),
        .NUM_CH      (NUM_CH),
        .DEFAULT_DIV (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .div_ratio (div_ratio),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int c, input int unsigned p, input int unsigned h);
        exp_t e;
        e.per = p;
        e.hi  = h;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop(input int c, output exp_t e);
        if (c == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    // Samples 1 time unit after each posedge; bench tasks sample at 2.
    task automatic monitor();
        int unsigned per [NUM_CH];
        int unsigned hi  [NUM_CH];
        bit          armed [NUM_CH];
        exp_t        e;
        for (int c = 0; c < NUM_CH; c++) begin
            per[c] = 0; hi[c] = 0; armed[c] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (reset || !mon_en[c]) begin
                    armed[c] = 1'b0;
                end else if (tick[c]) begin
                    if (armed[c] && qsize(c) > 0) begin
                        pop(c, e);
                        check($sformatf("ch%0d_period", c), per[c], e.per);
                        check($sformatf("ch%0d_high", c), hi[c], e.hi);
                    end
                    per[c]   = 1;
                    hi[c]    = 32'(clk_out[c]);
                    armed[c] = 1'b1;
                end else begin
                    per[c] = per[c] + 1;
                    hi[c]  = hi[c] + 32'(clk_out[c]);
                end
            end
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(input int c);
        int unsigned k = 0;
        do begin
            sample();
            k++;
        end while (tick[c] !== 1'b1 && k < BOUND);
        if (tick[c] !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_tick ch%0d: no tick within %0d cycles", c, BOUND);
        end
    endtask

    task automatic drain(input int c);
        int unsigned k = 0;
        while (qsize(c) != 0 && k < BOUND) begin
            sample();
            k++;
        end
        if (qsize(c) != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain ch%0d: %0d expected periods never seen", c, qsize(c));
            if (c == 0) q0.delete();
            else        q1.delete();
        end
    endtask

    task automatic edges_to_rise(input int c, output int unsigned n);
        n = 0;
        do begin
            sample();
            n++;
        end while (clk_out[c] !== 1'b1 && n < BOUND);
    endtask

    // Load is presented on the negedge and returns at the sample after the
    // capturing posedge.
    task automatic do_load(input int c, input logic [WIDTH-1:0] val);
        @(negedge clk);
        load[c] = 1'b1;
        div_ratio[c*WIDTH +: WIDTH] = val;
        sample();
        load[c] = 1'b0;
    endtask

    initial begin
        int unsigned n;
        reset     = 1'b1;
        enable    = '0;
        load      = '0;
        div_ratio = '0;
        mon_en    = '0;
        fork
            monitor();
        join_none

        // 1. reset state, first rise, default period
        #1;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick",    32'(tick),    0);
        check("rst_pending", 32'(pending), 0);
        enable = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        edges_to_rise(0, n);
        check("first_rise_edges", n, 4);
        check("first_rise_tick", 32'(tick[0]), 1);
        check("first_rise_ch1", 32'(clk_out[1]), 1);
        mon_en = 2'b11;
        push(0, 4, 2); push(0, 4, 2);
        push(1, 4, 2); push(1, 4, 2);
        drain(0);
        drain(1);

        // 2. ch0 load 6 mid-period: current period stays 4
        push(0, 4, 2); push(0, 6, 3); push(0, 6, 3);
        do_load(0, 8'd6);
        check("load6_pending0", 32'(pending[0]), 1);
        check("load6_pending1", 32'(pending[1]), 0);
        wait_tick(0);
        check("load6_pending_clr", 32'(pending[0]), 0);
        drain(0);

        // 3. ch1 load 5 (odd ratio)
        wait_tick(1);
        push(1, 4, 2); push(1, 5, HI5); push(1, 5, HI5);
        do_load(1, 8'd5);
        check("load5_pending1", 32'(pending[1]), 1);
        drain(1);

        // 4. ratios 0 and 1 clamp to 2
        wait_tick(0);
        push(0, 6, 3); push(0, 2, 1); push(0, 2, 1);
        do_load(0, 8'd0);
        drain(0);
        wait_tick(1);
        push(1, 5, HI5); push(1, 2, 1); push(1, 2, 1);
        do_load(1, 8'd1);
        drain(1);

        // 4b. load on the wrap cycle bypasses the shadow
        wait_tick(0);
        push(0, 2, 1); push(0, 3, HI3); push(0, 3, HI3);
        sample();
        do_load(0, 8'd3);
        check("bypass_tick", 32'(tick[0]), 1);
        check("bypass_pending", 32'(pending[0]), 0);
        drain(0);

        // 5. disable ch0 in its high phase; ch1 keeps running
        mon_en[0] = 1'b0;
        @(negedge clk);
        enable[0] = 1'b0;
        push(1, 2, 1); push(1, 2, 1); push(1, 2, 1);
        repeat (3) sample();
        check("frozen_clk_out", 32'(clk_out[0]), 1);
        check("frozen_tick", 32'(tick[0]), 0);
        drain(1);
        do_load(0, 8'd3);
        check("dis_load_clk_out", 32'(clk_out[0]), 0);
        check("dis_load_pending", 32'(pending[0]), 0);
        @(negedge clk);
        enable[0] = 1'b1;
        edges_to_rise(0, n);
        check("reenable_rise_edges", n, 3);

        // 6. reset while a load is pending
        do_load(0, 8'd7);
        check("pre_rst_pending", 32'(pending[0]), 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_clk_out", 32'(clk_out), 0);
        check("async_rst_tick",    32'(tick),    0);
        check("async_rst_pending", 32'(pending), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        edges_to_rise(0, n);
        check("post_rst_rise_edges", n, 4);
        mon_en[0] = 1'b1;
        push(0, 4, 2); push(0, 4, 2);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
